// File: rtl/fu_divsqrt_pkg.sv
// Shared definitions for the FU divide/square-root datapath.
//   state_e : control states of the SRT iteration engine
//   digit_e : radix-2 signed quotient digit {-1, 0, +1}
package fu_divsqrt_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DIG_Z = 2'b00,
        DIG_P = 2'b01,
        DIG_N = 2'b10
    } digit_e;

endpackage

// File: rtl/fu_divsqrt_srt_iter_csa.sv
// 3:2 carry-save adder row.
//   a, b, c : three W-bit addends
//   cin     : injected into the free LSB of the carry vector
//   sum     : bitwise sum
//   carry   : majority vector shifted left by one, cin in bit 0
// All arithmetic is modulo 2^W; the majority bit out of the MSB is dropped.
module fu_divsqrt_srt_iter_csa #(
    parameter int W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-2:0] maj;

    assign sum   = a ^ b ^ c;
    assign maj   = (a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]);
    assign carry = {maj, cin};

endmodule

// File: rtl/fu_divsqrt_srt_iter_nq.sv
// Negative-digit half of the radix-2 SRT quotient-digit table.
//   x  : 4-bit partial-remainder estimate, two's complement,
//        2 integer bits, resolution 1/4 (x[3] is the sign)
//   nq : 1 when digit -1 is selected
// An estimate of exactly -1/4 keeps the true remainder close enough to
// zero that digit 0 is chosen instead of -1.
module fu_divsqrt_srt_iter_nq (
    input  logic [3:0] x,
    output logic       nq
);

    assign nq = x[3] & (x != 4'b1111);

endmodule

// File: rtl/fu_divsqrt_srt_iter.sv
// Radix-2 SRT mantissa divide iteration engine.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start, flush  : launch (IDLE only) / abort to IDLE
//   dvd, dvr      : normalized 1.f mantissas, sampled with start
//   busy          : high in ITER, FIX and DONE
//   done          : one-cycle pulse when quo / flags are valid
//   quo           : quotient, bit WIDTH has weight 1, WIDTH fraction bits
//   rem_zero      : division was exact
//   rem_neg       : raw partial remainder was negative before correction
// The partial remainder is kept in carry-save form (WIDTH+4 bits, 2 integer
// bits) and only assimilated once, in FIX.
module fu_divsqrt_srt_iter
    import fu_divsqrt_pkg::*;
#(
    parameter int WIDTH = 53
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] dvr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   quo,
    output logic             rem_zero,
    output logic             rem_neg
);

    localparam int PW = WIDTH + 4;
    localparam int CW = $clog2(WIDTH + 1);

    state_e          state;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   pr_sum;
    logic [PW-1:0]   pr_carry;
    logic [PW-1:0]   d_pos;
    logic [WIDTH:0]  q_reg;
    logic [WIDTH:0]  qm_reg;

    logic [3:0]      x;
    logic            nq;
    logic            pq;
    digit_e          dig;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   csa_sum;
    logic [PW-1:0]   csa_carry;
    logic [PW-1:0]   pr_full;
    logic [PW-1:0]   pr_plus_d;

    // Estimate of PR from the top bits only; selecting on PR at resolution
    // 1/4 is the same as selecting on 2*PR at resolution 1/2.
    assign x  = pr_sum[PW-1 -: 4] + pr_carry[PW-1 -: 4];
    assign pq = ~x[3];

    fu_divsqrt_srt_iter_nq u_nq (
        .x  (x),
        .nq (nq)
    );

    always_comb begin
        dig = DIG_Z;
        if (pq)
            dig = DIG_P;
        else if (nq)
            dig = DIG_N;
    end

    // Subtracting D is done as ~D plus a carry-in in the empty carry LSB.
    always_comb begin
        addend = '0;
        case (dig)
            DIG_P:   addend = ~d_pos;
            DIG_N:   addend = d_pos;
            default: addend = '0;
        endcase
    end

    fu_divsqrt_srt_iter_csa #(
        .W (PW)
    ) u_csa (
        .a     ({pr_sum[PW-2:0], 1'b0}),
        .b     ({pr_carry[PW-2:0], 1'b0}),
        .c     (addend),
        .cin   (dig == DIG_P),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

    assign pr_full   = pr_sum + pr_carry;
    assign pr_plus_d = pr_full + d_pos;

    // Control and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quo      <= '0;
            rem_zero <= 1'b0;
            rem_neg  <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= S_ITER;
                        busy  <= 1'b1;
                        cnt   <= CW'(WIDTH);
                    end
                end
                S_ITER: begin
                    if (cnt == '0)
                        state <= S_FIX;
                    else
                        cnt <= cnt - CW'(1);
                end
                S_FIX: begin
                    state    <= S_DONE;
                    done     <= 1'b1;
                    // A negative final remainder means the last digit
                    // overshot by one ulp: QM already holds Q - ulp.
                    quo      <= pr_full[PW-1] ? qm_reg : q_reg;
                    rem_neg  <= pr_full[PW-1];
                    rem_zero <= (pr_full == '0) || (pr_full[PW-1] && (pr_plus_d == '0));
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath: partial remainder, divisor and on-the-fly quotient
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            pr_sum   <= {3'b000, dvd, 1'b0};
            pr_carry <= '0;
            d_pos    <= {2'b00, dvr, 2'b00};
            q_reg    <= '0;
            qm_reg   <= '1;
        end else if (state == S_ITER) begin
            pr_sum   <= csa_sum;
            pr_carry <= csa_carry;
            case (dig)
                DIG_P: begin
                    q_reg  <= {q_reg[WIDTH-1:0], 1'b1};
                    qm_reg <= {q_reg[WIDTH-1:0], 1'b0};
                end
                DIG_N: begin
                    q_reg  <= {qm_reg[WIDTH-1:0], 1'b1};
                    qm_reg <= {qm_reg[WIDTH-1:0], 1'b0};
                end
                default: begin
                    q_reg  <= {q_reg[WIDTH-1:0], 1'b0};
                    qm_reg <= {qm_reg[WIDTH-1:0], 1'b1};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fu_divsqrt_srt_iter.sv
module tb_fu_divsqrt_srt_iter;

    localparam int W = 8;
    localparam int N = W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         flush;
    logic [W-1:0] dvd;
    logic [W-1:0] dvr;
    logic         busy;
    logic         done;
    logic [W:0]   quo;
    logic         rem_zero;
    logic         rem_neg;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fu_divsqrt_srt_iter #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .flush    (flush),
        .dvd      (dvd),
        .dvr      (dvr),
        .busy     (busy),
        .done     (done),
        .quo      (quo),
        .rem_zero (rem_zero),
        .rem_neg  (rem_neg)
    );

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvr;
        logic [W:0]   quo;
        logic         rz;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one division and waits for done. lat counts cycles from the
    // cycle in which start is presented (cycle 0) to the done cycle; -1 on
    // timeout. Leaves the engine back in IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [W:0] q, output logic rz);
        lat   = -1;
        q     = '0;
        rz    = 1'b0;
        dvd   = a;
        dvr   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= N + 10; i++) begin
            tick();
            if (done) begin
                lat = i + 1;
                q   = quo;
                rz  = rem_zero;
                break;
            end
        end
        tick();
    endtask

    initial begin
        int          lat;
        logic [W:0]  q;
        logic        rz;
        int          ndone;
        logic        prev_done;
        int          exp_q;
        logic        exp_rz;

        vecs[0] = '{8'h80, 8'h80, 9'h100, 1'b1};
        vecs[1] = '{8'hC0, 8'h80, 9'h180, 1'b1};
        vecs[2] = '{8'h80, 8'hC0, 9'h0AA, 1'b0};
        vecs[3] = '{8'hFF, 8'h81, 9'h1FA, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 9'h100, 1'b1};
        vecs[5] = '{8'h80, 8'hFF, 9'h080, 1'b0};
        vecs[6] = '{8'hFF, 8'h80, 9'h1FE, 1'b1};
        vecs[7] = '{8'hA0, 8'hC8, 9'h0CC, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        dvd   = '0;
        dvr   = '0;
        repeat (3) tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quo", quo, 0);
        check("reset rem_zero", rem_zero, 0);
        check("reset rem_neg", rem_neg, 0);
        rst = 1'b0;
        tick();

        // directed table
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].dvd, vecs[i].dvr, lat, q, rz);
            check($sformatf("latency[%0d]", i), lat, N + 2);
            check($sformatf("quo[%0d]", i), q, vecs[i].quo);
            check($sformatf("rem_zero[%0d]", i), rz, vecs[i].rz);
            check($sformatf("busy after done[%0d]", i), busy, 0);
        end

        // sweep: every dividend against every 8th divisor
        for (int a = 128; a < 256; a++) begin
            for (int b = 128; b < 256; b += 8) begin
                exp_q  = (a * 256) / b;
                exp_rz = ((a * 256) % b) == 0;
                run_op(W'(a), W'(b), lat, q, rz);
                check($sformatf("sweep quo %0h/%0h", a, b), q, exp_q);
                check($sformatf("sweep rem_zero %0h/%0h", a, b), rz, exp_rz);
            end
        end

        // flush in the 4th ITER cycle, then watch that no done appears
        dvd   = 8'h80;
        dvr   = 8'h80;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", busy, 0);
        check("flush done", done, 0);
        ndone = 0;
        for (int i = 0; i < N + 4; i++) begin
            tick();
            if (done) ndone++;
        end
        check("flush no done", ndone, 0);

        // flush again, immediate restart
        dvd   = 8'hFF;
        dvr   = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        run_op(8'hC0, 8'h80, lat, q, rz);
        check("restart latency", lat, N + 2);
        check("restart quo", q, 9'h180);

        // flush and start together in IDLE: no launch
        dvd   = 8'h80;
        dvr   = 8'hC0;
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flush+start busy", busy, 0);
        ndone = 0;
        for (int i = 0; i < N + 4; i++) begin
            tick();
            if (done) ndone++;
        end
        check("flush+start no done", ndone, 0);
        check("flush+start quo held", quo, 9'h180);

        // reset in the middle of ITER clears every output
        dvd   = 8'hC0;
        dvr   = 8'h80;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst quo", quo, 0);
        check("midrst rem_zero", rem_zero, 0);
        check("midrst rem_neg", rem_neg, 0);
        rst = 1'b0;
        tick();

        // start held high: one op per IDLE entry, N+3 cycles apart
        dvd       = 8'hC0;
        dvr       = 8'h80;
        start     = 1'b1;
        ndone     = 0;
        prev_done = 1'b0;
        for (int i = 0; i < 2 * (N + 3); i++) begin
            tick();
            if (done) begin
                ndone++;
                check($sformatf("held done spacing %0d", i), prev_done, 0);
            end
            prev_done = done;
        end
        start = 1'b0;
        check("held done count", ndone, 2);
        check("held quo", quo, 9'h180);
        check("held busy end", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
